// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan scheduler.
// Packet length depends on ADC_SCAN_CHECKSUM_EN (defined: 4-byte packet with checksum).
package adc_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_REQ,
    ST_WAIT_ADC,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_GAP
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam logic [7:0] TO_DATA_DEF  = 8'hFF;

  localparam int BIDX_W = 2;

`ifdef ADC_SCAN_CHECKSUM_EN
  localparam int PKT_LEN = 4;
`else
  localparam int PKT_LEN = 3;
`endif

  localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(PKT_LEN - 1);

endpackage

// File: rtl/adc_scan_prienc.sv
// Combinational finder: lowest set bit of mask at an index >= cursor.
module adc_scan_prienc (
  input  logic [7:0] mask,
  input  logic [3:0] cursor,
  output logic [2:0] idx,
  output logic       found
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Descending scan: the last hit written is the lowest qualifying index.
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= cursor)) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// Scans the masked ADC channels in ascending order and frames each result as a UART packet.
// Optional checksum byte is enabled with the ADC_SCAN_CHECKSUM_EN macro.
module adc_scan_sched
  import adc_scan_pkg::*;
#(
  parameter int         SCAN_GAP    = 50000,
  parameter int         ADC_TIMEOUT = 4096,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter logic [7:0] TO_DATA     = TO_DATA_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] chan_mask,
  output logic       adc_req,
  output logic [2:0] adc_addr,
  input  logic       adc_valid,
  input  logic [7:0] adc_data,
  output logic       tx_send,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err_timeout
);

  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam int GW = $clog2(SCAN_GAP + 1);

  state_e              state_q, state_d;
  logic [7:0]          mask_q;
  logic [3:0]          cursor_q;
  logic [2:0]          addr_q;
  logic [7:0]          sample_q;
  logic [BIDX_W-1:0]   bidx_q;
  logic [TW-1:0]       tmo_q;
  logic [GW-1:0]       gap_q;
  logic [1:0]          rdy_sync;
  logic                err_q;
  logic                rdy_s;
  logic                tmo_hit;
  logic [2:0]          pe_idx;
  logic                pe_found;
  logic [7:0]          cur_byte;

  assign rdy_s   = rdy_sync[1];
  assign tmo_hit = (tmo_q == TW'(ADC_TIMEOUT - 1));

  adc_scan_prienc u_prienc (
    .mask   (mask_q),
    .cursor (cursor_q),
    .idx    (pe_idx),
    .found  (pe_found)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (enable && (chan_mask != 8'd0)) state_d = ST_PICK;
      ST_PICK:      state_d = pe_found ? ST_REQ : ST_GAP;
      ST_REQ:       state_d = ST_WAIT_ADC;
      ST_WAIT_ADC:  if (adc_valid || tmo_hit) state_d = ST_SEND;
      ST_SEND:      state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (!rdy_s) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        if (rdy_s) begin
          if (bidx_q != LAST_BIDX)  state_d = ST_SEND;
          else if (addr_q == 3'd7)  state_d = ST_GAP;
          else                      state_d = ST_PICK;
        end
      end
      ST_GAP:       if (gap_q == GW'(SCAN_GAP - 1)) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      cursor_q <= '0;
      addr_q   <= '0;
      sample_q <= '0;
      bidx_q   <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      rdy_sync <= 2'b11;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_sync <= {rdy_sync[0], tx_ready};
      gap_q    <= (state_q == ST_GAP) ? gap_q + 1'b1 : '0;
      unique case (state_q)
        ST_IDLE: begin
          if (enable && (chan_mask != 8'd0)) begin
            mask_q   <= chan_mask;
            cursor_q <= '0;
          end
        end
        ST_PICK: if (pe_found) addr_q <= pe_idx;
        ST_REQ:  tmo_q <= '0;
        ST_WAIT_ADC: begin
          if (adc_valid) begin
            sample_q <= adc_data;
            bidx_q   <= '0;
          end else if (tmo_hit) begin
            sample_q <= TO_DATA;
            err_q    <= 1'b1;
            bidx_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rdy_s) begin
            if (bidx_q != LAST_BIDX) bidx_q   <= bidx_q + 1'b1;
            else                     cursor_q <= {1'b0, addr_q} + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    unique case (bidx_q)
      2'd0:    cur_byte = HDR_BYTE;
      2'd1:    cur_byte = {5'b0, addr_q};
      2'd2:    cur_byte = sample_q;
      default: begin
`ifdef ADC_SCAN_CHECKSUM_EN
        cur_byte = HDR_BYTE + {5'b0, addr_q} + sample_q;
`else
        cur_byte = 8'h00;
`endif
      end
    endcase
  end

  assign adc_req     = (state_q == ST_REQ);
  assign adc_addr    = addr_q;
  assign tx_send     = (state_q == ST_SEND) || (state_q == ST_WAIT_ACK);
  assign tx_data     = tx_send ? cur_byte : 8'h00;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;

endmodule

// File: doc/adc_scan_sched.md
Name: adc_scan_sched

Overview:
- Sequences the 8-channel ADC controller through a programmable set of channels.
- Frames each conversion result into a byte packet and hands it to the UART transmitter.
- Sits between the ADC controller (conversion request/valid) and uart_tx (send/ready).
- Replaces the ad-hoc "send when data nonzero" logic with a deterministic scan loop.

Parameters:
- SCAN_GAP, 50000: idle clock cycles between the end of one full scan and the start of the next; minimum 1.
- ADC_TIMEOUT, 4096: clock cycles to wait for adc_valid before aborting a conversion.
- HDR_BYTE, 8'hA5: first byte of every packet.
- TO_DATA, 8'hFF: data byte substituted when a conversion times out.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  scanning allowed; sampled only in IDLE
- chan_mask  in  8  channels to scan; bit n = channel n; latched at scan start
- adc_req  out  1  one-cycle pulse that starts a conversion
- adc_addr  out  3  channel select; held stable from adc_req until adc_valid or timeout
- adc_valid  in  1  one-cycle pulse; adc_data valid this cycle
- adc_data  in  8  conversion result
- tx_send  out  1  byte available on tx_data
- tx_data  out  8  byte to transmit
- tx_ready  in  1  uart_tx idle; may be asynchronous-domain slow; 2-flop synchronised internally
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky; set on any ADC timeout; cleared only by reset

Behaviour:
- Reset values: adc_req=0, adc_addr=0, tx_send=0, tx_data=0, busy=0, err_timeout=0, state=IDLE, all counters=0.
- Reset is honoured mid-packet. Any partially sent packet is abandoned; no resume.
- States: IDLE, PICK, REQ, WAIT_ADC, SEND, WAIT_ACK, WAIT_IDLE, GAP.
- IDLE:
  - If enable=1 and chan_mask!=0: latch mask_q=chan_mask, set cursor=0, go to PICK.
  - If mask==0: remain in IDLE; busy stays 0.
- PICK:
  - Find the lowest set bit of mask_q at index >= cursor and load it into adc_addr; go to REQ.
  - If no such bit exists, the scan is complete; go to GAP.
- REQ: assert adc_req for exactly one cycle; clear the timeout counter; go to WAIT_ADC.
- WAIT_ADC:
  - On adc_valid: capture adc_data into sample_q.
  - If the counter reaches ADC_TIMEOUT-1 without adc_valid: sample_q=TO_DATA and set err_timeout.
  - Either way: byte index=0; go to SEND.
  - adc_valid arriving outside WAIT_ADC is ignored.
- Packet bytes, in order: HDR_BYTE, {5'b0, adc_addr}, sample_q, then the checksum byte if the feature is enabled.
- SEND: drive tx_data with the current byte, assert tx_send, go to WAIT_ACK.
- WAIT_ACK: hold tx_send and tx_data until the synchronised tx_ready is seen low (transmission started), then deassert tx_send; go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait for the synchronised tx_ready to be high.
  - If more bytes remain: advance the byte index and go to SEND.
  - Otherwise: cursor=adc_addr+1 and go to PICK. If adc_addr==7, go directly to GAP; no wrap within a scan.
- GAP:
  - Count SCAN_GAP cycles, then go to IDLE.
  - enable=0 at any point lets the current scan finish; IDLE then holds.
- Latency from adc_valid to the first tx_send rising edge is exactly 1 cycle.
- Changes to chan_mask during a scan take effect at the next scan.

Optional Feature:
- Macro: ADC_SCAN_CHECKSUM_EN.
- Defined: the packet is 4 bytes. Fourth byte = 8-bit wrap-around sum of HDR_BYTE + channel byte + sample_q, with the carry discarded.
- Undefined: the packet is 3 bytes; no checksum logic is synthesised.

Decomposition:
- Package adc_scan_pkg:
  - State enum.
  - HDR_BYTE and TO_DATA defaults.
  - Byte-index width.
  - PKT_LEN constant: 3, or 4 when ADC_SCAN_CHECKSUM_EN is defined.
- One sub-module: adc_scan_prienc.
  - Combinational next-set-bit finder.
  - Inputs mask[7:0] and cursor[3:0]; outputs idx[2:0] and found.
  - Instantiated by PICK.

Test Plan:
- mask=8'b0000_0101, enable=1, ADC model returns 8'h3C after 20 cycles: tx bytes A5,00,3C then A5,02,3C, then SCAN_GAP idle, then repeat. adc_addr must never show 1.
- mask=8'h80 (cursor edge): exactly one packet per scan, A5,07,data, then GAP.
- mask=0, enable=1: busy stays 0; no adc_req pulse for 10k cycles.
- ADC model never asserts adc_valid: after ADC_TIMEOUT cycles the packet A5,ch,FF is sent and err_timeout=1 stays set across later good scans.
- Assert reset during the second byte, with tx_send high: all outputs return to reset values asynchronously. After release, the next packet starts at HDR_BYTE.
- With ADC_SCAN_CHECKSUM_EN defined, channel 3, data 8'hF0: bytes A5,03,F0,98, since (A5+03+F0) mod 256 = 98.
